// File: rtl/reg_psr.sv
// reg_psr
// -------
// Processor status register. It holds the six architectural flags
// (N, V, D, I, Z, C) as individual flip-flops. Each flag has its own
// load strobes, and a flag that sees none of its strobes keeps its value.
// The status byte is {N, V, 1, 1, D, I, Z, C}. Bit 5 is always 1, and the
// B position (bit 4) always reads 1.
//
// Ports
//   CLK        : clock; all state changes happen on its rising edge
//   RST        : synchronous active-high reset -> P = 8'h34
//   C_LOAD_DB0 : C <= DATA[0]
//   C_LOAD_IR5 : C <= IR5        (CLC/SEC)
//   C_LOAD_ACR : C <= ACR        (ALU carry out)
//   Z_LOAD_DB1 : Z <= DATA[1]
//   Z_LOAD_DBZ : Z <= (DATA == 0)
//   I_LOAD_DB2 : I <= DATA[2]
//   I_LOAD_IR5 : I <= IR5        (CLI/SEI)
//   D_LOAD_DB3 : D <= DATA[3]
//   D_LOAD_IR5 : D <= IR5        (CLD/SED)
//   V_LOAD_DB6 : V <= DATA[6]
//   V_LOAD_AVR : V <= AVR        (ALU overflow)
//   V_LOAD_I   : V <= 0          (CLV)
//   N_LOAD_DB7 : N <= DATA[7]
//   BUS_ENABLE : drive the status byte onto OUT
//   DATA       : internal data bus
//   IR5        : instruction register bit 5
//   ACR        : ALU carry out
//   AVR        : ALU overflow
//   OUT        : status byte when BUS_ENABLE=1, else 8'h00
//   P          : status byte, always driven
module reg_psr (
  input  logic       CLK,
  input  logic       RST,
  input  logic       C_LOAD_DB0,
  input  logic       C_LOAD_IR5,
  input  logic       C_LOAD_ACR,
  input  logic       Z_LOAD_DB1,
  input  logic       Z_LOAD_DBZ,
  input  logic       I_LOAD_DB2,
  input  logic       I_LOAD_IR5,
  input  logic       D_LOAD_DB3,
  input  logic       D_LOAD_IR5,
  input  logic       V_LOAD_DB6,
  input  logic       V_LOAD_AVR,
  input  logic       V_LOAD_I,
  input  logic       N_LOAD_DB7,
  input  logic       BUS_ENABLE,
  input  logic [7:0] DATA,
  input  logic       IR5,
  input  logic       ACR,
  input  logic       AVR,
  output logic [7:0] OUT,
  output logic [7:0] P
);

  logic flag_c;
  logic flag_z;
  logic flag_i;
  logic flag_d;
  logic flag_v;
  logic flag_n;
  logic data_is_zero;

  assign data_is_zero = (DATA == 8'h00);

  // Each flag is updated on its own. The if/else chain order inside a flag
  // sets which strobe wins when several of them target the same flag.
  // Reset sets I so that interrupts start out masked.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_i <= 1'b1;
      flag_d <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      if (C_LOAD_DB0)      flag_c <= DATA[0];
      else if (C_LOAD_IR5) flag_c <= IR5;
      else if (C_LOAD_ACR) flag_c <= ACR;

      if (Z_LOAD_DB1)      flag_z <= DATA[1];
      else if (Z_LOAD_DBZ) flag_z <= data_is_zero;

      if (I_LOAD_DB2)      flag_i <= DATA[2];
      else if (I_LOAD_IR5) flag_i <= IR5;

      if (D_LOAD_DB3)      flag_d <= DATA[3];
      else if (D_LOAD_IR5) flag_d <= IR5;

      if (V_LOAD_DB6)      flag_v <= DATA[6];
      else if (V_LOAD_AVR) flag_v <= AVR;
      else if (V_LOAD_I)   flag_v <= 1'b0;

      if (N_LOAD_DB7)      flag_n <= DATA[7];
    end
  end

  // P and OUT are purely combinational from the flags. A load therefore
  // shows up right after the edge that captures it.
  assign P   = {flag_n, flag_v, 1'b1, 1'b1, flag_d, flag_i, flag_z, flag_c};
  assign OUT = BUS_ENABLE ? P : 8'h00;

endmodule

// File: tb/tb_reg_psr.sv
// tb_reg_psr
// ----------
// Directed testbench for reg_psr. Each task exercises one feature and
// compares P/OUT against hand-computed status bytes.
module tb_reg_psr;

  logic       CLK = 1'b0;
  logic       RST;
  logic       C_LOAD_DB0, C_LOAD_IR5, C_LOAD_ACR;
  logic       Z_LOAD_DB1, Z_LOAD_DBZ;
  logic       I_LOAD_DB2, I_LOAD_IR5;
  logic       D_LOAD_DB3, D_LOAD_IR5;
  logic       V_LOAD_DB6, V_LOAD_AVR, V_LOAD_I;
  logic       N_LOAD_DB7;
  logic       BUS_ENABLE;
  logic [7:0] DATA;
  logic       IR5, ACR, AVR;
  logic [7:0] OUT;
  logic [7:0] P;

  int total = 0;
  int bad   = 0;

  reg_psr dut (
    .CLK(CLK), .RST(RST),
    .C_LOAD_DB0(C_LOAD_DB0), .C_LOAD_IR5(C_LOAD_IR5), .C_LOAD_ACR(C_LOAD_ACR),
    .Z_LOAD_DB1(Z_LOAD_DB1), .Z_LOAD_DBZ(Z_LOAD_DBZ),
    .I_LOAD_DB2(I_LOAD_DB2), .I_LOAD_IR5(I_LOAD_IR5),
    .D_LOAD_DB3(D_LOAD_DB3), .D_LOAD_IR5(D_LOAD_IR5),
    .V_LOAD_DB6(V_LOAD_DB6), .V_LOAD_AVR(V_LOAD_AVR), .V_LOAD_I(V_LOAD_I),
    .N_LOAD_DB7(N_LOAD_DB7), .BUS_ENABLE(BUS_ENABLE), .DATA(DATA),
    .IR5(IR5), .ACR(ACR), .AVR(AVR), .OUT(OUT), .P(P)
  );

  always #5 CLK = ~CLK;

  // One rising edge. Inputs change and outputs are sampled 1 time unit
  // after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_strobes();
    C_LOAD_DB0 = 0; C_LOAD_IR5 = 0; C_LOAD_ACR = 0;
    Z_LOAD_DB1 = 0; Z_LOAD_DBZ = 0;
    I_LOAD_DB2 = 0; I_LOAD_IR5 = 0;
    D_LOAD_DB3 = 0; D_LOAD_IR5 = 0;
    V_LOAD_DB6 = 0; V_LOAD_AVR = 0; V_LOAD_I = 0;
    N_LOAD_DB7 = 0;
  endtask

  task automatic do_reset();
    clear_strobes();
    RST = 1;
    tick();
    RST = 0;
  endtask

  task automatic test_reset();
    clear_strobes();
    BUS_ENABLE = 1; DATA = 8'hFF; IR5 = 1; ACR = 1; AVR = 1;
    RST = 1;
    tick(); tick();
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL reset_p actual=%h required=%h", P, 8'h34); end
    total++;
    if (OUT !== 8'h34) begin bad++; $display("[TB] FAIL reset_out_en actual=%h required=%h", OUT, 8'h34); end
    BUS_ENABLE = 0; #1;
    total++;
    if (OUT !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_dis actual=%h required=%h", OUT, 8'h00); end
    RST = 0;
  endtask

  task automatic test_c_flag();
    do_reset();
    DATA = 8'hFF; ACR = 1; IR5 = 0;
    C_LOAD_DB0 = 1; tick(); C_LOAD_DB0 = 0;
    total++;
    if (P !== 8'h35) begin bad++; $display("[TB] FAIL c_db0 actual=%h required=%h", P, 8'h35); end
    C_LOAD_IR5 = 1; tick(); C_LOAD_IR5 = 0;
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL c_ir5 actual=%h required=%h", P, 8'h34); end
    C_LOAD_ACR = 1; tick(); C_LOAD_ACR = 0;
    total++;
    if (P !== 8'h35) begin bad++; $display("[TB] FAIL c_acr actual=%h required=%h", P, 8'h35); end
    // Inputs that change while no strobe is asserted must not be captured.
    DATA = 8'h00; ACR = 0; tick();
    total++;
    if (P !== 8'h35) begin bad++; $display("[TB] FAIL c_hold actual=%h required=%h", P, 8'h35); end
  endtask

  task automatic test_z_flag();
    do_reset();
    DATA = 8'hFF;
    Z_LOAD_DB1 = 1; tick(); Z_LOAD_DB1 = 0;
    total++;
    if (P !== 8'h36) begin bad++; $display("[TB] FAIL z_db1 actual=%h required=%h", P, 8'h36); end
    Z_LOAD_DBZ = 1; tick();
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL z_dbz_ff actual=%h required=%h", P, 8'h34); end
    DATA = 8'h00; tick();
    total++;
    if (P !== 8'h36) begin bad++; $display("[TB] FAIL z_dbz_00 actual=%h required=%h", P, 8'h36); end
    DATA = 8'h80; tick();
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL z_dbz_80 actual=%h required=%h", P, 8'h34); end
    DATA = 8'h00; tick();
    DATA = 8'h01; tick(); Z_LOAD_DBZ = 0;
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL z_dbz_01 actual=%h required=%h", P, 8'h34); end
  endtask

  task automatic test_i_d_flags();
    do_reset();
    DATA = 8'hFF; IR5 = 0;
    I_LOAD_IR5 = 1; tick(); I_LOAD_IR5 = 0;
    total++;
    if (P !== 8'h30) begin bad++; $display("[TB] FAIL i_ir5_clr actual=%h required=%h", P, 8'h30); end
    I_LOAD_DB2 = 1; tick(); I_LOAD_DB2 = 0;
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL i_db2 actual=%h required=%h", P, 8'h34); end
    I_LOAD_IR5 = 1; tick(); I_LOAD_IR5 = 0;
    total++;
    if (P !== 8'h30) begin bad++; $display("[TB] FAIL i_ir5 actual=%h required=%h", P, 8'h30); end
    D_LOAD_DB3 = 1; tick(); D_LOAD_DB3 = 0;
    total++;
    if (P !== 8'h38) begin bad++; $display("[TB] FAIL d_db3 actual=%h required=%h", P, 8'h38); end
    D_LOAD_IR5 = 1; tick(); D_LOAD_IR5 = 0;
    total++;
    if (P !== 8'h30) begin bad++; $display("[TB] FAIL d_ir5_clr actual=%h required=%h", P, 8'h30); end
    IR5 = 1; D_LOAD_IR5 = 1; tick(); D_LOAD_IR5 = 0;
    total++;
    if (P !== 8'h38) begin bad++; $display("[TB] FAIL d_ir5_set actual=%h required=%h", P, 8'h38); end
  endtask

  task automatic test_v_n_flags();
    do_reset();
    DATA = 8'hFF; AVR = 0;
    V_LOAD_DB6 = 1; tick(); V_LOAD_DB6 = 0;
    total++;
    if (P !== 8'h74) begin bad++; $display("[TB] FAIL v_db6 actual=%h required=%h", P, 8'h74); end
    V_LOAD_AVR = 1; tick(); V_LOAD_AVR = 0;
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL v_avr actual=%h required=%h", P, 8'h34); end
    V_LOAD_DB6 = 1; tick(); V_LOAD_DB6 = 0;
    V_LOAD_I = 1; tick(); V_LOAD_I = 0;
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL v_clv actual=%h required=%h", P, 8'h34); end
    N_LOAD_DB7 = 1; tick(); N_LOAD_DB7 = 0;
    total++;
    if (P !== 8'hB4) begin bad++; $display("[TB] FAIL n_db7 actual=%h required=%h", P, 8'hB4); end
    AVR = 1; V_LOAD_AVR = 1; tick(); V_LOAD_AVR = 0;
    total++;
    if (P !== 8'hF4) begin bad++; $display("[TB] FAIL v_avr_set actual=%h required=%h", P, 8'hF4); end
  endtask

  task automatic test_priority();
    do_reset();
    ACR = 1; C_LOAD_ACR = 1; tick();
    DATA = 8'hFE; C_LOAD_DB0 = 1; tick(); C_LOAD_DB0 = 0;
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL prio_c_db0_acr actual=%h required=%h", P, 8'h34); end
    tick();
    IR5 = 0; C_LOAD_IR5 = 1; tick(); C_LOAD_IR5 = 0; C_LOAD_ACR = 0;
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL prio_c_ir5_acr actual=%h required=%h", P, 8'h34); end
    DATA = 8'h00; Z_LOAD_DBZ = 1; tick();
    Z_LOAD_DB1 = 1; tick(); Z_LOAD_DB1 = 0; Z_LOAD_DBZ = 0;
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL prio_z actual=%h required=%h", P, 8'h34); end
    IR5 = 1; I_LOAD_DB2 = 1; I_LOAD_IR5 = 1; tick(); I_LOAD_DB2 = 0; I_LOAD_IR5 = 0;
    total++;
    if (P !== 8'h30) begin bad++; $display("[TB] FAIL prio_i actual=%h required=%h", P, 8'h30); end
    IR5 = 1; D_LOAD_IR5 = 1; tick();
    D_LOAD_DB3 = 1; tick(); D_LOAD_DB3 = 0; D_LOAD_IR5 = 0;
    total++;
    if (P !== 8'h30) begin bad++; $display("[TB] FAIL prio_d actual=%h required=%h", P, 8'h30); end
    AVR = 1; V_LOAD_AVR = 1; V_LOAD_I = 1; tick();
    total++;
    if (P !== 8'h70) begin bad++; $display("[TB] FAIL prio_v_avr_clv actual=%h required=%h", P, 8'h70); end
    V_LOAD_DB6 = 1; tick(); V_LOAD_DB6 = 0; V_LOAD_AVR = 0; V_LOAD_I = 0;
    total++;
    if (P !== 8'h30) begin bad++; $display("[TB] FAIL prio_v_db6 actual=%h required=%h", P, 8'h30); end
    DATA = 8'hFF; N_LOAD_DB7 = 1; tick();
    RST = 1; C_LOAD_DB0 = 1; V_LOAD_DB6 = 1; tick(); RST = 0;
    clear_strobes();
    total++;
    if (P !== 8'h34) begin bad++; $display("[TB] FAIL prio_rst_over_load actual=%h required=%h", P, 8'h34); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    DATA = 8'hFF;
    C_LOAD_DB0 = 1; Z_LOAD_DB1 = 1; I_LOAD_DB2 = 1; D_LOAD_DB3 = 1; V_LOAD_DB6 = 1; N_LOAD_DB7 = 1;
    tick();
    total++;
    if (P !== 8'hFF) begin bad++; $display("[TB] FAIL simul_ff actual=%h required=%h", P, 8'hFF); end
    DATA = 8'h00; tick();
    clear_strobes();
    total++;
    if (P !== 8'h30) begin bad++; $display("[TB] FAIL simul_00 actual=%h required=%h", P, 8'h30); end
  endtask

  task automatic test_bus_timing();
    do_reset();
    BUS_ENABLE = 1; DATA = 8'hFF; N_LOAD_DB7 = 1; #1;
    total++;
    if (OUT !== 8'h34) begin bad++; $display("[TB] FAIL bus_pre_edge actual=%h required=%h", OUT, 8'h34); end
    tick(); N_LOAD_DB7 = 0;
    total++;
    if (OUT !== 8'hB4) begin bad++; $display("[TB] FAIL bus_post_edge actual=%h required=%h", OUT, 8'hB4); end
    BUS_ENABLE = 0; #1;
    total++;
    if (OUT !== 8'h00) begin bad++; $display("[TB] FAIL bus_disabled actual=%h required=%h", OUT, 8'h00); end
    total++;
    if (P !== 8'hB4) begin bad++; $display("[TB] FAIL p_when_disabled actual=%h required=%h", P, 8'hB4); end
  endtask

  initial begin
    clear_strobes();
    RST = 1; BUS_ENABLE = 0; DATA = 8'h00; IR5 = 0; ACR = 0; AVR = 0;
    #2;
    test_reset();
    test_c_flag();
    test_z_flag();
    test_i_d_flags();
    test_v_n_flags();
    test_priority();
    test_simultaneous();
    test_bus_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_psr.md
REG_PSR -- requirements
Module: reg_psr

Interface
REQ-001 Parameters: none.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 C_LOAD_DB0  in  1  C <= DATA[0].
REQ-005 C_LOAD_IR5  in  1  C <= IR5 (CLC/SEC).
REQ-006 C_LOAD_ACR  in  1  C <= ACR (ALU carry out).
REQ-007 Z_LOAD_DB1  in  1  Z <= DATA[1].
REQ-008 Z_LOAD_DBZ  in  1  Z <= (DATA == 8'h00).
REQ-009 I_LOAD_DB2  in  1  I <= DATA[2].
REQ-010 I_LOAD_IR5  in  1  I <= IR5 (CLI/SEI).
REQ-011 D_LOAD_DB3  in  1  D <= DATA[3].
REQ-012 D_LOAD_IR5  in  1  D <= IR5 (CLD/SED).
REQ-013 V_LOAD_DB6  in  1  V <= DATA[6].
REQ-014 V_LOAD_AVR  in  1  V <= AVR (ALU overflow).
REQ-015 V_LOAD_I  in  1  V <= 0 (CLV).
REQ-016 N_LOAD_DB7  in  1  N <= DATA[7].
REQ-017 BUS_ENABLE  in  1  drive status byte onto OUT.
REQ-018 DATA  in  8  internal data bus value.
REQ-019 IR5, ACR, AVR  in  1 each  instruction bit 5, ALU carry, ALU overflow.
REQ-020 OUT  out  8  status byte when BUS_ENABLE=1, else 8'h00.
REQ-021 P  out  8  status byte, always driven (for branch/ALU logic).

Function
REQ-022 Status byte layout: {N, V, 1, 1, D, I, Z, C}; bit 5 constant 1, bit 4 (B) reads 1.
REQ-023 Each flag is a flip-flop updated on rising CLK only when one of its load strobes is 1; otherwise it holds.
REQ-024 Flags update independently; strobes for different flags in the same cycle all take effect.
REQ-025 Same-flag conflict priority (highest first): C: DB0 > IR5 > ACR; Z: DB1 > DBZ; I: DB2 > IR5; D: DB3 > IR5; V: DB6 > AVR > V_LOAD_I.
REQ-026 Z_LOAD_DBZ compares all 8 DATA bits; Z=1 only for DATA=8'h00.
REQ-027 OUT and P are combinational from the flag registers and BUS_ENABLE; a load takes effect on OUT/P immediately after the loading edge (1-cycle latency from strobe).
REQ-028 Load and BUS_ENABLE in the same cycle: OUT shows the pre-edge value until the edge, then the new value.
REQ-029 DATA, IR5, ACR, AVR are sampled only at the edge where the relevant strobe is 1.

Reset
REQ-030 RST=1 at rising CLK: C=0, Z=0, I=1, D=0, V=0, N=0, i.e. P=8'h34; RST overrides all load strobes.
REQ-031 During/after reset OUT = 8'h34 if BUS_ENABLE=1, else 8'h00.

Verification
REQ-032 Reset, BUS_ENABLE=1 -> OUT=8'h34; BUS_ENABLE=0 -> OUT=8'h00.
REQ-033 DATA=8'hFF, ACR=1, IR5=0: pulse C_LOAD_DB0 -> C=1; C_LOAD_IR5 -> C=0; C_LOAD_ACR -> C=1; other bits unchanged.
REQ-034 DATA=8'hFF: Z_LOAD_DB1 -> Z=1; Z_LOAD_DBZ -> Z=0; DATA=8'h00, Z_LOAD_DBZ -> Z=1.
REQ-035 DATA=8'hFF, IR5=0: I_LOAD_DB2 -> I=1, I_LOAD_IR5 -> I=0; D_LOAD_DB3 -> D=1, D_LOAD_IR5 -> D=0.
REQ-036 DATA=8'hFF, AVR=0: V_LOAD_DB6 -> V=1; V_LOAD_AVR -> V=0; V_LOAD_DB6 then V_LOAD_I -> V=0; N_LOAD_DB7 -> N=1; all with bit 5 = 1.
REQ-037 Simultaneous C_LOAD_DB0 (DATA[0]=0) and C_LOAD_ACR (ACR=1) -> C=0; simultaneous RST and N_LOAD_DB7 -> N=0.
